fp_sum_sequencer: RTL

FP_SUM_SEQUENCER -- requirements
Module: fp_sum_sequencer

---
 rtl/fp_sum_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/fp_sum_sequencer.sv
// fp_sum_sequencer: accumulates a vector of single-precision operands through
// an external combinational fp_adder, one operand per ADD cycle, and presents
// the sum, operand count and an Inf/NaN sticky flag with a valid/ready handshake.
module fp_sum_sequencer #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   input  logic               in_last,
   output logic [31:0]        add_a,
   output logic [31:0]        add_b,
   input  logic [31:0]        add_s,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_sum,
   output logic [COUNT_W-1:0] out_count,
   output logic               out_special
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ADD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        acc_q, acc_d;
   logic [31:0]        op_q, op_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               spec_q, spec_d;
   logic               last_q, last_d;
   logic               in_hs;
   logic               out_hs;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + {{(COUNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Adder operands come only from registers so in_data never reaches the adder combinationally.
   assign add_a       = acc_q;
   assign add_b       = op_q;
   assign out_sum     = acc_q;
   assign out_count   = cnt_q;
   assign out_special = spec_q;

   // Next-state, handshake outputs and datapath register updates.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      spec_d    = spec_q;
      last_d    = last_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      in_hs     = 1'b0;
      out_hs    = 1'b0;
      case (state_q)
         S_IDLE, S_WAIT: begin
            in_ready = 1'b1;
            in_hs    = in_valid;
            if (in_hs) begin
               op_d    = in_data;
               last_d  = in_last;
               spec_d  = spec_q | (in_data[30:23] == 8'hFF);
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            acc_d   = add_s;
            cnt_d   = sat_inc(cnt_q);
            state_d = last_q ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            out_valid = 1'b1;
            out_hs    = out_ready;
            if (out_hs) begin
               acc_d   = 32'h0000_0000;
               cnt_d   = '0;
               spec_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset returns everything to an empty accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= 32'h0000_0000;
         op_q    <= 32'h0000_0000;
         cnt_q   <= '0;
         spec_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         spec_q  <= spec_d;
         last_q  <= last_d;
      end
   end

endmodule
